aes_round_ctrl: RTL and testbench

Sequencer for the 32-bit-radix AES round datapath (aes_rounddata). It accepts a 128-bit block and a key-size mode over valid/ready, then steps the datapath through round 0 (AddRoundKey only) and rounds 1..Nr at four word-slots per round. It holds the 128-bit state register between rounds, requests round keys from the key schedule, and returns the ciphertext over a valid/ready output port. It sits between the block-level I/O wrapper and the round datapath/key-expansion pair.

---
 rtl/aes_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the 32-bit-radix AES round datapath.
// Accepts a 128-bit block plus key-size mode, runs round 0 (AddRoundKey)
// and rounds 1..Nr at four word slots per round, and holds the state
// register between rounds. It requests the matching round key and
// returns the ciphertext over valid/ready.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   in_valid/in_ready       block input handshake (in_mode, in_data)
//   out_valid/out_ready     ciphertext handshake (out_data = state register)
//   key_round, key_valid    round-key request/indication (key_round = dp_round)
//   dp_round, dp_width_sel  round number and word slot to the datapath
//   dp_mode, dp_data_in     latched mode and state register to the datapath
//   dp_data_out             datapath AddRoundKey result
//
// Optional build macro AES_ROUND_CTRL_PERF_EN adds the blocks_done
// (handshake count, wrapping) and stall_cycles (key stall count,
// saturating) outputs.
module aes_round_ctrl #(
  parameter logic [3:0] NR_128 = 4'd10,
  parameter logic [3:0] NR_192 = 4'd12,
  parameter logic [3:0] NR_256 = 4'd14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   key_round,
  input  logic         key_valid,
  output logic [3:0]   dp_round,
  output logic [1:0]   dp_width_sel,
  output logic [1:0]   dp_mode,
  output logic [127:0] dp_data_in,
  input  logic [127:0] dp_data_out
`ifdef AES_ROUND_CTRL_PERF_EN
  ,
  output logic [31:0]  blocks_done,
  output logic [15:0]  stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, R0, RUN, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [1:0]   mode_q, mode_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [1:0]   ws_q, ws_d;

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b00:   nr_of = NR_128;
      2'b01:   nr_of = NR_192;
      default: nr_of = NR_256;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      mode_q <= 2'b00;
      nr_q   <= NR_128;
      rnd_q  <= '0;
      ws_q   <= '0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      mode_q <= mode_d;
      nr_q   <= nr_d;
      rnd_q  <= rnd_d;
      ws_q   <= ws_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    blk_d        = blk_q;
    mode_d       = mode_q;
    nr_d         = nr_q;
    rnd_d        = rnd_q;
    ws_d         = ws_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    dp_round     = '0;
    dp_width_sel = '0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d  = in_data;
          mode_d = in_mode;
          nr_d   = nr_of(in_mode);
          rnd_d  = '0;
          ws_d   = '0;
          fsm_d  = R0;
        end
      end
      R0: begin
        if (key_valid) begin
          blk_d = dp_data_out;
          rnd_d = 4'd1;
          ws_d  = '0;
          fsm_d = RUN;
        end
      end
      RUN: begin
        dp_round     = rnd_q;
        dp_width_sel = ws_q;
        // key_valid only gates the start of a round; the datapath
        // accumulator is free-running, so slots 1..3 never stall.
        if (ws_q == 2'd0 && !key_valid) begin
          ws_d = ws_q;
        end else if (ws_q == 2'd3) begin
          blk_d = dp_data_out;
          if (rnd_q == nr_q) begin
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
            ws_d  = '0;
          end
        end else begin
          ws_d = ws_q + 2'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_data   = blk_q;
  assign dp_data_in = blk_q;
  assign dp_mode    = mode_q;
  assign key_round  = dp_round;

`ifdef AES_ROUND_CTRL_PERF_EN
  logic [31:0] blocks_q;
  logic [15:0] stall_q;
  logic        stall_now;

  assign stall_now = !key_valid &&
                     (fsm_q == R0 || (fsm_q == RUN && ws_q == 2'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blocks_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_valid && out_ready) blocks_q <= blocks_q + 32'd1;
      if (stall_now && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign blocks_done  = blocks_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl. A behavioural AES round model stands in for
// the datapath and key schedule; ciphertexts are the FIPS-197 appendix C
// values held in a vector table and queued when each block is driven.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, key_valid;
  logic [1:0]   in_mode, dp_width_sel, dp_mode;
  logic [127:0] in_data, out_data, dp_data_in, dp_data_out;
  logic [3:0]   key_round, dp_round;
`ifdef AES_ROUND_CTRL_PERF_EN
  logic [31:0]  blocks_done;
  logic [15:0]  stall_cycles;
`endif

  aes_round_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_round(key_round), .key_valid(key_valid),
    .dp_round(dp_round), .dp_width_sel(dp_width_sel), .dp_mode(dp_mode),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out)
`ifdef AES_ROUND_CTRL_PERF_EN
    , .blocks_done(blocks_done), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] rk [3][15];
  logic [255:0] key_all = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  bit           init_done = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gmul(p, x);  // x^254 = inverse, 0 -> 0
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int m, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key_all[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[m][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [3:0] r,
                                            input logic [1:0] m);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    int mi, nr;
    mi = (m == 2'd3) ? 2 : int'(m);
    nr = 10 + 2*mi;
    if (r == 4'd0) return s ^ rk[mi][0];
    if (int'(r) > nr) return '0;
    for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[4*c+w] = b[4*((c+w)%4)+w];
    if (int'(r) != nr) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk[mi][r];
  endfunction

  // Without a key the datapath result is junk; capturing it corrupts the block.
  always @(dp_data_in or dp_round or dp_mode or key_valid or init_done)
    dp_data_out = (key_valid && init_done) ? dp_model(dp_data_in, dp_round, dp_mode)
                                           : {4{32'hBAD0BAD0}};

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [1:0]   mode;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  vec_t         vt [4];
  logic [127:0] exp_q [$];

  task automatic run_block(input logic [1:0] mode, input logic [127:0] pt, input logic [127:0] ct,
                           input int lat, input int stall_r0, input int stall_rnd,
                           input int stall_n, input int bp, input bit noise);
    int         cyc, left;
    bit         stl;
    logic [3:0] prev_rnd;
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_mode = mode; in_data = pt;
    exp_q.push_back(ct);
    @(posedge clk);
    @(negedge clk);
    in_valid = noise; in_mode = ~mode; in_data = ~pt;
    cyc = 0; left = stall_n; stl = 1'b0; prev_rnd = '0;
    while (!out_valid && cyc <= 200) begin
      if (stl) begin
        chk("stall_ws_hold", dp_width_sel, 2'd0);
        chk("stall_round_hold", dp_round, prev_rnd);
      end
      if (cyc == 2) begin
        chk("in_ready_busy", in_ready, 1'b0);
        chk("dp_mode_latched", dp_mode, mode);
        chk("key_round_eq", key_round, dp_round);
      end
      stl = 1'b0;
      if (cyc < stall_r0) stl = 1'b1;
      else if (left > 0 && dp_round == stall_rnd[3:0] && dp_width_sel == 2'd0) begin
        stl = 1'b1;
        left--;
      end
      key_valid = !stl;
      prev_rnd  = dp_round;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    key_valid = 1'b1;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout: got no out_valid after %0d cycles, required %0d", cyc, lat);
      in_valid = 1'b0;
      return;
    end
    chk("latency", cyc, lat);
    for (int i = 0; i < bp; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_stable", out_data, ct);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got output %h, required none", out_data);
    end else begin
      chk("ciphertext", out_data, exp_q.pop_front());
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    bit found;
    vt[0] = '{2'b00, PT, CT128, 41};
    vt[1] = '{2'b01, PT, CT192, 49};
    vt[2] = '{2'b10, PT, CT256, 57};
    vt[3] = '{2'b11, PT, CT256, 57};

    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    expand(0, 4, 10);
    expand(1, 6, 12);
    expand(2, 8, 14);
    init_done = 1'b1;

    reset = 1'b1; in_valid = 1'b0; in_mode = '0; in_data = '0;
    out_ready = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dp_round", dp_round, 4'd0);
    chk("rst_dp_ws", dp_width_sel, 2'd0);
    chk("rst_dp_mode", dp_mode, 2'b00);
    chk("rst_out_data", out_data, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back table vectors; first with in_valid noise, second with backpressure.
    for (int i = 0; i < 4; i++)
      run_block(vt[i].mode, vt[i].pt, vt[i].ct, vt[i].lat, 0, 0, 0,
                (i == 1) ? 10 : 0, i == 0);

    // Key stalls: 3 cycles in R0, 5 cycles at round 4 slot 0.
    run_block(2'b00, PT, CT128, 49, 3, 4, 5, 0, 1'b0);

    // Reset mid-block at round 6, slot 2.
    in_valid = 1'b1; in_mode = 2'b00; in_data = PT;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dp_round == 4'd6 && dp_width_sel == 2'd2) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("reach_r6_ws2", found, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_dp_round", dp_round, 4'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_block(2'b00, PT, CT128, 41, 0, 0, 0, 0, 1'b0);

    // Counter run: three blocks, 4 stall cycles in total.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`ifdef AES_ROUND_CTRL_PERF_EN
    chk("perf_rst_blocks", blocks_done, 32'd0);
    chk("perf_rst_stalls", stall_cycles, 16'd0);
`endif
    run_block(2'b00, PT, CT128, 42, 1, 0, 0, 0, 1'b0);
    run_block(2'b00, PT, CT128, 44, 0, 2, 3, 0, 1'b0);
    run_block(2'b00, PT, CT128, 41, 0, 0, 0, 0, 1'b0);
`ifdef AES_ROUND_CTRL_PERF_EN
    chk("perf_blocks_done", blocks_done, 32'd3);
    chk("perf_stall_cycles", stall_cycles, 16'd4);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
